// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime baud divisor, 5..9 data bits, optional
// even/odd parity, 3-sample majority voting and a valid/ready output with overrun flag.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  input  logic [DIV_W-1:0]     divisor,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o,
  output logic [2:0]           dbg_state_o
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int B_W = $clog2(DATA_BITS);
  localparam logic [S_W-1:0] S_LO   = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0] S_VOTE = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic                 rx_meta, rx_s, rx_d;
  logic                 fall;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [S_W-1:0]       s_cnt;
  logic                 samp_a, samp_b;
  logic                 vote, vote_tick, bit_end;
  logic [B_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           par_mode_r;
  logic                 par_en, acc, perr;
  logic                 complete, accept;

  // Synchronizer flops reset to the idle level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall      = rx_d & ~rx_s;
  assign tick      = (state != IDLE) && (div_cnt == divisor);
  assign vote      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign vote_tick = tick && (s_cnt == S_VOTE);
  assign bit_end   = tick && (s_cnt == S_LAST);
  assign par_en    = (par_mode_r == 2'd1) || (par_mode_r == 2'd2);
  assign complete  = (state == STOP) && vote_tick;
  assign accept    = valid_o & ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      s_cnt   <= '0;
      samp_a  <= 1'b0;
      samp_b  <= 1'b0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      s_cnt   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      s_cnt   <= (s_cnt == S_LAST) ? '0 : s_cnt + S_W'(1);
      if (s_cnt == S_LO)  samp_a <= rx_s;
      if (s_cnt == S_MID) samp_b <= rx_s;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // STOP completes at its vote tick, so a following start bit is never missed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fall) state_nx = START;
      START: begin
        if (vote_tick && vote) state_nx = IDLE;
        else if (bit_end)      state_nx = DATA;
      end
      DATA:    if (bit_end && bit_cnt == B_LAST) state_nx = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) state_nx = STOP;
      STOP:    if (vote_tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_mode_r <= 2'd0;
      acc        <= 1'b0;
      perr       <= 1'b0;
    end else begin
      if (state == IDLE && fall) begin
        par_mode_r <= parity_mode;
        acc        <= 1'b0;
        bit_cnt    <= '0;
      end
      if (state == DATA && vote_tick) begin
        shreg <= {vote, shreg[DATA_BITS-1:1]};
        acc   <= acc ^ vote;
      end
      if (state == DATA && bit_end) bit_cnt <= bit_cnt + B_W'(1);
      if (state == PARITY && vote_tick)
        perr <= (par_mode_r == 2'd1) ? (acc ^ vote) : ~(acc ^ vote);
    end
  end

  // Output handshake: a frame is held while valid_o=1 and leaves when valid_o&ready_i;
  // a completion may reload in the same cycle as that handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else if (complete) begin
      if (!valid_o || ready_i) begin
        data_o       <= shreg;
        parity_err_o <= par_en & perr;
        frame_err_o  <= ~vote;
        valid_o      <= 1'b1;
        if (accept) overrun_o <= 1'b0;
      end else begin
        overrun_o <= 1'b1;
      end
    end else if (accept) begin
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end
  end

  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames driven on the line, expected words queued
// and compared at each output handshake, plus timing and flag checks.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i, ready_i;
  logic [15:0] divisor;
  logic [1:0] parity_mode;
  logic [7:0] data_o;
  logic       valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;
  logic [2:0] dbg_state_o;

  logic       rx2_i, ready2_i;
  logic [15:0] divisor2;
  logic [1:0] parity_mode2;
  logic [6:0] data2_o;
  logic       valid2_o, parity_err2_o, frame_err2_o, overrun2_o, busy2_o;
  logic [2:0] dbg_state2_o;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_cfg dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .divisor(divisor),
    .parity_mode(parity_mode), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_i(rx2_i), .divisor(divisor2),
    .parity_mode(parity_mode2), .data_o(data2_o), .valid_o(valid2_o),
    .ready_i(ready2_i), .parity_err_o(parity_err2_o), .frame_err_o(frame_err2_o),
    .overrun_o(overrun2_o), .busy_o(busy2_o), .dbg_state_o(dbg_state2_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame, one bit per bit_clks negedges; optional glitch and early abort.
  task automatic send_frame(input int sel, input int nbits, input logic [8:0] data,
                            input logic par_on, input logic par_bit, input logic stop_bit,
                            input int bit_clks, input int glitch_bit, input int glitch_at,
                            input int glitch_len, input int abort_clk);
    logic [11:0] bits;
    int n;
    int clk_n;
    logic v;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[1+i] = data[i];
    n = 1 + nbits;
    if (par_on) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n] = stop_bit;
    n++;
    clk_n = 0;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < bit_clks; k++) begin
        if (abort_clk >= 0 && clk_n == abort_clk) return;
        v = bits[b] ^ (b == glitch_bit && k >= glitch_at && k < glitch_at + glitch_len);
        if (sel == 0) rx_i = v;
        else          rx2_i = v;
        @(negedge clk);
        clk_n++;
      end
    end
  endtask

  task automatic tx(input logic [7:0] data, input logic par_on, input logic par_bit,
                    input logic stop_bit);
    send_frame(0, 8, {1'b0, data}, par_on, par_bit, stop_bit, 16 * (int'(divisor) + 1),
               -1, 0, 0, -1);
  endtask

  // Scoreboard: compare the held frame against the queue whenever it is accepted.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && valid_o === 1'b1) begin
      valid_cnt++;
      if (ready_i === 1'b1) begin
        chk("frame_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("frame", {parity_err_o, frame_err_o, data_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rx_i = 1'b1;
    rx2_i = 1'b1;
    ready_i = 1'b1;
    ready2_i = 1'b1;
    divisor = 16'd53;
    divisor2 = 16'd53;
    parity_mode = 2'd0;
    parity_mode2 = 2'd0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_perr", parity_err_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_state", dbg_state_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 at 115200 with a 100 MHz clock; STOP vote tick lands 8318 clk after the edge.
    valid_cnt = 0;
    exp_q.push_back({2'b00, 8'hA5});
    fork
      tx(8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (8318) @(negedge clk);
        chk("t1_valid_before", valid_o, 0);
        @(negedge clk);
        chk("t1_valid_rise", valid_o, 1);
        chk("t1_data", data_o, 8'hA5);
        chk("t1_perr", parity_err_o, 0);
        chk("t1_ferr", frame_err_o, 0);
      end
    join
    repeat (20) @(negedge clk);
    chk("t1_valid_one_cycle", valid_cnt, 1);
    chk("t1_busy_after", busy_o, 0);

    // False start: 3-tick low pulse.
    divisor = 16'd3;
    valid_cnt = 0;
    fork
      begin
        rx_i = 1'b0;
        repeat (12) @(negedge clk);
        rx_i = 1'b1;
      end
      begin
        repeat (2) @(negedge clk);
        chk("fs_busy_pre", busy_o, 0);
        @(negedge clk);
        chk("fs_busy_rise", busy_o, 1);
        repeat (61) @(negedge clk);
        chk("fs_busy_fell", busy_o, 0);
      end
    join
    repeat (100) @(negedge clk);
    chk("fs_no_valid", valid_cnt, 0);

    // Parity even then odd on 0x07.
    parity_mode = 2'd1;
    exp_q.push_back({2'b00, 8'h07});
    tx(8'h07, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({2'b10, 8'h07});
    tx(8'h07, 1'b1, 1'b0, 1'b1);
    parity_mode = 2'd2;
    exp_q.push_back({2'b10, 8'h07});
    tx(8'h07, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({2'b00, 8'h07});
    tx(8'h07, 1'b1, 1'b0, 1'b1);
    parity_mode = 2'd0;
    repeat (10) @(negedge clk);
    chk("par_data_held", data_o, 8'h07);

    // Glitch of one tick at the middle sample of data bit 3.
    exp_q.push_back({2'b00, 8'hB6});
    send_frame(0, 8, 9'h0B6, 1'b0, 1'b0, 1'b1, 64, 4, 33, 4, -1);

    // Framing error then line held low.
    valid_cnt = 0;
    exp_q.push_back({2'b01, 8'h81});
    tx(8'h81, 1'b0, 1'b0, 1'b0);
    repeat (1920) @(negedge clk);
    chk("brk_busy", busy_o, 0);
    chk("brk_one_frame", valid_cnt, 1);
    rx_i = 1'b1;
    repeat (64) @(negedge clk);
    exp_q.push_back({2'b00, 8'h3C});
    tx(8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);

    // Overrun, then a completion coinciding with a handshake.
    ready_i = 1'b0;
    exp_q.push_back({2'b00, 8'h11});
    tx(8'h11, 1'b0, 1'b0, 1'b1);
    tx(8'h22, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("ovr_valid", valid_o, 1);
    chk("ovr_data_kept", data_o, 8'h11);
    chk("ovr_flag", overrun_o, 1);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    @(negedge clk);
    chk("ovr_valid_cleared", valid_o, 0);
    chk("ovr_flag_cleared", overrun_o, 0);
    exp_q.push_back({2'b00, 8'h33});
    tx(8'h33, 1'b0, 1'b0, 1'b1);
    chk("coin_held", data_o, 8'h33);
    exp_q.push_back({2'b00, 8'h44});
    fork
      tx(8'h44, 1'b0, 1'b0, 1'b1);
      begin
        repeat (618) @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("coin_data", data_o, 8'h44);
        chk("coin_valid", valid_o, 1);
        chk("coin_overrun", overrun_o, 0);
      end
    join

    // Reset during data bit 3 while 0x44 is still held.
    send_frame(0, 8, 9'h096, 1'b0, 1'b0, 1'b1, 64, -1, 0, 0, 288);
    chk("rst2_busy_pre", busy_o, 1);
    rx_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", valid_o, 0);
    chk("rst2_data", data_o, 0);
    chk("rst2_flags", {parity_err_o, frame_err_o, overrun_o}, 0);
    chk("rst2_busy", busy_o, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    ready_i = 1'b1;
    exp_q.push_back({2'b00, 8'h5D});
    tx(8'h5D, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);

    // 7 data bits, oversample 8, divisor 53: vote tick 3782 clk after the edge.
    fork
      send_frame(1, 7, 9'h055, 1'b0, 1'b0, 1'b1, 8 * 54, -1, 0, 0, -1);
      begin
        repeat (3782) @(negedge clk);
        chk("d7_valid_before", valid2_o, 0);
        @(negedge clk);
        chk("d7_valid_rise", valid2_o, 1);
        chk("d7_data", data2_o, 7'h55);
        chk("d7_flags", {parity_err2_o, frame_err2_o, overrun2_o}, 0);
      end
    join
    repeat (10) @(negedge clk);
    chk("d7_busy_after", busy2_o, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
